// File: rtl/lfsr_stream.sv
// Fibonacci LFSR stream source: STEP single-bit shifts per valid/ready handshake,
// loadable taps and seed, lock-up recovery and period-done detection against the seed.
module lfsr_stream #(
    parameter int                  NUM_BITS     = 32,
    parameter int                  STEP         = 8,
    parameter int                  MODE         = 0,
    parameter logic [NUM_BITS-1:0] DEFAULT_TAPS = NUM_BITS'(32'h80200003),
    parameter logic [NUM_BITS-1:0] DEFAULT_SEED = NUM_BITS'(1)
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    input  logic                i_Taps_DV,
    input  logic [NUM_BITS-1:0] i_Taps_Data,
    output logic [STEP-1:0]     o_Data,
    output logic                o_Valid,
    input  logic                i_Ready,
    output logic                o_Period_Done,
    output logic                o_Lockup
);

    localparam bit                  LP_XNOR = (MODE != 0);
    localparam logic [NUM_BITS-1:0] LP_LOCK = {NUM_BITS{LP_XNOR}};
    localparam logic [NUM_BITS-1:0] LP_MSB  = {1'b1, {(NUM_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_RECOVER
    } state_t;

    state_t              r_Fsm;
    state_t              w_Fsm_Next;
    logic [NUM_BITS-1:0] r_State;
    logic [NUM_BITS-1:0] r_Seed;
    logic [NUM_BITS-1:0] r_Taps;
    logic                r_Period_Done;
    logic                r_Lockup;
    logic [NUM_BITS-1:0] w_Next;
    logic                w_Seed_Hit;
    logic                w_Lock_Hit;
    logic                w_Advance;

    // Unrolled advance: every intermediate state is compared with the seed so a
    // period boundary crossed mid-advance is still reported.
    always_comb begin : p_unroll
        logic [NUM_BITS-1:0] w_walk;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        w_walk     = r_State;
        w_Seed_Hit = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            w_walk = {w_walk[NUM_BITS-2:0], (^(w_walk & r_Taps)) ^ LP_XNOR};
            if (w_walk == r_Seed) begin
                w_Seed_Hit = 1'b1;
            end
        end
        w_Next = w_walk;
    end

    always_ff @(posedge i_Clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!i_Rst_n) begin
            r_Fsm <= S_INIT;
        end else begin
            r_Fsm <= w_Fsm_Next;
        end
    end

    always_comb begin
        w_Fsm_Next = r_Fsm;
        w_Lock_Hit = 1'b0;
        case (r_Fsm)
            S_INIT:    w_Fsm_Next = S_RUN;
            S_RUN: begin
                if (!i_Seed_DV && (r_State == LP_LOCK)) begin
                    w_Fsm_Next = S_RECOVER;
                    w_Lock_Hit = 1'b1;
                end
            end
            S_RECOVER: w_Fsm_Next = S_RUN;
            default:   w_Fsm_Next = S_INIT;
        endcase
    end

    assign w_Advance = (r_Fsm == S_RUN) && i_Ready;

    // Seed load beats lock-up recovery, which beats a normal advance.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_State       <= DEFAULT_SEED;
            r_Seed        <= DEFAULT_SEED;
            r_Period_Done <= 1'b0;
            r_Lockup      <= 1'b0;
        end else begin
            r_Period_Done <= 1'b0;
            if (i_Seed_DV) begin
                r_State  <= i_Seed_Data;
                r_Seed   <= i_Seed_Data;
                r_Lockup <= 1'b0;
            end else if (w_Lock_Hit) begin
                r_State  <= DEFAULT_SEED;
                r_Seed   <= DEFAULT_SEED;
                r_Lockup <= 1'b1;
            end else if (w_Advance) begin
                r_State       <= w_Next;
                r_Period_Done <= w_Seed_Hit;
            end
        end
    end

    // A new mask only affects advances from the next cycle on; the MSB tap is mandatory.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_Taps <= DEFAULT_TAPS;
        end else if (i_Taps_DV) begin
            r_Taps <= i_Taps_Data | LP_MSB;
        end
    end

    assign o_Data        = r_State[STEP-1:0];
    assign o_Valid       = (r_Fsm == S_RUN);
    assign o_Period_Done = r_Period_Done;
    assign o_Lockup      = r_Lockup;

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: three 4-bit instances (STEP 1 XOR, STEP 4 XOR, STEP 4 XNOR)
// share one stimulus set; expected words come from a hand-derived x^4+x^3+1 sequence table.
module tb_lfsr_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, seed_dv, taps_dv, ready;
    logic [3:0] seed_data, taps_data;
    logic [0:0] d1_data;
    logic       d1_valid, d1_pd, d1_lock;
    logic [3:0] d4_data;
    logic       d4_valid, d4_pd, d4_lock;
    logic [3:0] dx_data;
    logic       dx_valid, dx_pd, dx_lock;

    int n_vec = 0;
    int n_err = 0;
    int p1, p4, sidx;
    logic [3:0] m1, m4, mx;

    // States reached from 0001 with taps 1100 (XOR), index = number of single steps mod 15.
    logic [3:0] seq [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                             4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                             4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    lfsr_stream #(.NUM_BITS(4), .STEP(1), .MODE(0), .DEFAULT_TAPS(4'b1100), .DEFAULT_SEED(4'b0001)) u_dut1 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Seed_DV(seed_dv), .i_Seed_Data(seed_data),
        .i_Taps_DV(taps_dv), .i_Taps_Data(taps_data), .o_Data(d1_data), .o_Valid(d1_valid),
        .i_Ready(ready), .o_Period_Done(d1_pd), .o_Lockup(d1_lock));

    lfsr_stream #(.NUM_BITS(4), .STEP(4), .MODE(0), .DEFAULT_TAPS(4'b1100), .DEFAULT_SEED(4'b0001)) u_dut4 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Seed_DV(seed_dv), .i_Seed_Data(seed_data),
        .i_Taps_DV(taps_dv), .i_Taps_Data(taps_data), .o_Data(d4_data), .o_Valid(d4_valid),
        .i_Ready(ready), .o_Period_Done(d4_pd), .o_Lockup(d4_lock));

    lfsr_stream #(.NUM_BITS(4), .STEP(4), .MODE(1), .DEFAULT_TAPS(4'b1100), .DEFAULT_SEED(4'b0001)) u_dutx (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Seed_DV(seed_dv), .i_Seed_Data(seed_data),
        .i_Taps_DV(taps_dv), .i_Taps_Data(taps_data), .o_Data(dx_data), .o_Valid(dx_valid),
        .i_Ready(ready), .o_Period_Done(dx_pd), .o_Lockup(dx_lock));

    function automatic logic [3:0] lfsr_adv(input logic [3:0] s, input logic [3:0] taps,
                                            input bit xn, input int n);
        logic [3:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = {v[2:0], (^(v & taps)) ^ xn};
        return v;
    endfunction

    // {valid, period_done, data} for the STEP=1 instance at step position p.
    function automatic logic [2:0] exp1(input int p, input bit adv);
        logic [3:0] s;
        s = seq[p % 15];
        return {1'b1, adv && ((p % 15) == sidx), s[0]};
    endfunction

    // STEP=4 pulses when any of the four steps p-3..p lands on the seed index.
    function automatic logic [5:0] exp4(input int p, input bit adv);
        return {1'b1, adv && (((p + 15 - sidx) % 15) < 4), seq[p % 15]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; seed_dv = 1'b0; taps_dv = 1'b0; ready = 1'b0;
        seed_data = 4'b0000; taps_data = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        p1 = 0; p4 = 0; sidx = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; seed_dv = 1'b0; taps_dv = 1'b0; ready = 1'b1;
        seed_data = 4'b0000; taps_data = 4'b0000;
        tick();
        n_vec++;
        if ({d1_valid, d1_pd, d1_lock, d1_data} !== 4'b0001) begin
            n_err++; $display("FAIL reset_d1: got %b expected %b", {d1_valid, d1_pd, d1_lock, d1_data}, 4'b0001);
        end
        n_vec++;
        if ({d4_valid, d4_pd, d4_lock, d4_data} !== 7'b000_0001) begin
            n_err++; $display("FAIL reset_d4: got %b expected %b", {d4_valid, d4_pd, d4_lock, d4_data}, 7'b000_0001);
        end
        n_vec++;
        if ({dx_valid, dx_pd, dx_lock, dx_data} !== 7'b000_0001) begin
            n_err++; $display("FAIL reset_dx: got %b expected %b", {dx_valid, dx_pd, dx_lock, dx_data}, 7'b000_0001);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({d4_valid, d4_pd, d4_data} !== 6'b10_0001) begin
            n_err++; $display("FAIL init_to_run: got %b expected %b", {d4_valid, d4_pd, d4_data}, 6'b10_0001);
        end
        tick();
        n_vec++;
        if ({d4_valid, d4_pd, d4_data} !== 6'b10_0011) begin
            n_err++; $display("FAIL first_word_d4: got %b expected %b", {d4_valid, d4_pd, d4_data}, 6'b10_0011);
        end
        n_vec++;
        if ({d1_valid, d1_pd, d1_data} !== 3'b100) begin
            n_err++; $display("FAIL first_word_d1: got %b expected %b", {d1_valid, d1_pd, d1_data}, 3'b100);
        end
        n_vec++;
        if ({dx_valid, dx_pd, dx_data} !== 6'b10_1101) begin
            n_err++; $display("FAIL first_word_dx: got %b expected %b", {dx_valid, dx_pd, dx_data}, 6'b10_1101);
        end
    endtask

    task automatic test_sequence();
        do_reset();
        ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(); p1++; p4 += 4;
            n_vec++;
            if ({d1_valid, d1_pd, d1_data} !== exp1(p1, 1'b1)) begin
                n_err++; $display("FAIL seq_d1 word %0d: got %b expected %b", k, {d1_valid, d1_pd, d1_data}, exp1(p1, 1'b1));
            end
            n_vec++;
            if ({d4_valid, d4_pd, d4_data} !== exp4(p4, 1'b1)) begin
                n_err++; $display("FAIL seq_d4 word %0d: got %b expected %b", k, {d4_valid, d4_pd, d4_data}, exp4(p4, 1'b1));
            end
        end
        // Seed load with a live handshake: load wins, nothing advances, no pulse.
        seed_dv = 1'b1; seed_data = 4'b0110;
        tick();
        seed_dv = 1'b0; p1 = 5; p4 = 5; sidx = 5;
        n_vec++;
        if ({d1_valid, d1_pd, d1_data} !== exp1(p1, 1'b0)) begin
            n_err++; $display("FAIL seed_wins_d1: got %b expected %b", {d1_valid, d1_pd, d1_data}, exp1(p1, 1'b0));
        end
        n_vec++;
        if ({d4_valid, d4_pd, d4_data} !== exp4(p4, 1'b0)) begin
            n_err++; $display("FAIL seed_wins_d4: got %b expected %b", {d4_valid, d4_pd, d4_data}, exp4(p4, 1'b0));
        end
        for (int k = 1; k <= 20; k++) begin
            tick(); p1++; p4 += 4;
            n_vec++;
            if ({d1_valid, d1_pd, d1_data} !== exp1(p1, 1'b1)) begin
                n_err++; $display("FAIL reseed_d1 word %0d: got %b expected %b", k, {d1_valid, d1_pd, d1_data}, exp1(p1, 1'b1));
            end
            n_vec++;
            if ({d4_valid, d4_pd, d4_data} !== exp4(p4, 1'b1)) begin
                n_err++; $display("FAIL reseed_d4 word %0d: got %b expected %b", k, {d4_valid, d4_pd, d4_data}, exp4(p4, 1'b1));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            ready = (k <= 4 || k > 9) ? 1'b1 : 1'b0;
            tick();
            if (ready) begin
                p1++; p4 += 4;
            end
            n_vec++;
            if ({d1_valid, d1_pd, d1_data} !== exp1(p1, ready)) begin
                n_err++; $display("FAIL bp_d1 cycle %0d: got %b expected %b", k, {d1_valid, d1_pd, d1_data}, exp1(p1, ready));
            end
            n_vec++;
            if ({d4_valid, d4_pd, d4_data} !== exp4(p4, ready)) begin
                n_err++; $display("FAIL bp_d4 cycle %0d: got %b expected %b", k, {d4_valid, d4_pd, d4_data}, exp4(p4, ready));
            end
        end
    endtask

    task automatic test_lockup();
        logic [6:0] exp_d4 [4];
        logic [6:0] exp_dx [4];
        logic [3:0] seeds  [4];
        do_reset();
        ready = 1'b1;
        // XOR instance: load 0000, recover, advance once, reseed.
        seeds  = '{4'b0000, 4'b0000, 4'b0000, 4'b0100};
        exp_d4 = '{7'b100_0000, 7'b001_0001, 7'b101_0001, 7'b101_0011};
        for (int k = 0; k < 4; k++) begin
            seed_dv = (k == 0); seed_data = seeds[k];
            tick();
            n_vec++;
            if ({d4_valid, d4_pd, d4_lock, d4_data} !== exp_d4[k]) begin
                n_err++; $display("FAIL lock_xor cycle %0d: got %b expected %b", k, {d4_valid, d4_pd, d4_lock, d4_data}, exp_d4[k]);
            end
        end
        n_vec++;
        if ({d1_valid, d1_lock, d1_data} !== 3'b110) begin
            n_err++; $display("FAIL lock_xor_d1: got %b expected %b", {d1_valid, d1_lock, d1_data}, 3'b110);
        end
        seed_dv = 1'b1; seed_data = 4'b0100;
        tick();
        n_vec++;
        if ({d4_valid, d4_pd, d4_lock, d4_data} !== 7'b100_0100) begin
            n_err++; $display("FAIL lock_clear_d4: got %b expected %b", {d4_valid, d4_pd, d4_lock, d4_data}, 7'b100_0100);
        end
        // XNOR instance: lock-up value is all-ones.
        seeds  = '{4'b1111, 4'b1111, 4'b1111, 4'b0110};
        exp_dx = '{7'b100_1111, 7'b001_0001, 7'b101_0001, 7'b100_0110};
        for (int k = 0; k < 4; k++) begin
            seed_dv = (k == 0 || k == 3); seed_data = seeds[k];
            tick();
            n_vec++;
            if ({dx_valid, dx_pd, dx_lock, dx_data} !== exp_dx[k]) begin
                n_err++; $display("FAIL lock_xnor cycle %0d: got %b expected %b", k, {dx_valid, dx_pd, dx_lock, dx_data}, exp_dx[k]);
            end
        end
        seed_dv = 1'b0;
    endtask

    task automatic test_taps();
        do_reset();
        ready = 1'b1; m1 = 4'b0001; m4 = 4'b0001; mx = 4'b0001;
        // Mask 0001 is loaded as 1001 (MSB forced); the concurrent advance still uses 1100.
        for (int k = 0; k < 7; k++) begin
            taps_dv = (k == 0); taps_data = 4'b0001;
            tick();
            m1 = lfsr_adv(m1, (k == 0) ? 4'b1100 : 4'b1001, 1'b0, 1);
            m4 = lfsr_adv(m4, (k == 0) ? 4'b1100 : 4'b1001, 1'b0, 4);
            mx = lfsr_adv(mx, (k == 0) ? 4'b1100 : 4'b1001, 1'b1, 4);
            n_vec++;
            if ({d1_valid, d1_data} !== {1'b1, m1[0]}) begin
                n_err++; $display("FAIL taps_d1 word %0d: got %b expected %b", k, {d1_valid, d1_data}, {1'b1, m1[0]});
            end
            n_vec++;
            if ({d4_valid, d4_data} !== {1'b1, m4}) begin
                n_err++; $display("FAIL taps_d4 word %0d: got %b expected %b", k, {d4_valid, d4_data}, {1'b1, m4});
            end
            n_vec++;
            if ({dx_valid, dx_data} !== {1'b1, mx}) begin
                n_err++; $display("FAIL taps_dx word %0d: got %b expected %b", k, {dx_valid, dx_data}, {1'b1, mx});
            end
        end
        taps_dv = 1'b0;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        ready = 1'b1;
        taps_dv = 1'b1; taps_data = 4'b1001; seed_dv = 1'b1; seed_data = 4'b0000;
        tick();
        taps_dv = 1'b0; seed_dv = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        rst_n = 1'b0;
        tick();
        n_vec++;
        if ({d4_valid, d4_pd, d4_lock, d4_data} !== 7'b000_0001) begin
            n_err++; $display("FAIL midreset_d4: got %b expected %b", {d4_valid, d4_pd, d4_lock, d4_data}, 7'b000_0001);
        end
        n_vec++;
        if ({dx_valid, dx_pd, dx_lock, dx_data} !== 7'b000_0001) begin
            n_err++; $display("FAIL midreset_dx: got %b expected %b", {dx_valid, dx_pd, dx_lock, dx_data}, 7'b000_0001);
        end
        rst_n = 1'b1;
        tick();
        p1 = 0; p4 = 0; sidx = 0;
        n_vec++;
        if ({d4_valid, d4_pd, d4_data} !== exp4(0, 1'b0)) begin
            n_err++; $display("FAIL midreset_restart: got %b expected %b", {d4_valid, d4_pd, d4_data}, exp4(0, 1'b0));
        end
        for (int k = 1; k <= 15; k++) begin
            tick(); p1++; p4 += 4;
            n_vec++;
            if ({d1_valid, d1_pd, d1_data} !== exp1(p1, 1'b1)) begin
                n_err++; $display("FAIL fresh_d1 word %0d: got %b expected %b", k, {d1_valid, d1_pd, d1_data}, exp1(p1, 1'b1));
            end
            n_vec++;
            if ({d4_valid, d4_pd, d4_data} !== exp4(p4, 1'b1)) begin
                n_err++; $display("FAIL fresh_d4 word %0d: got %b expected %b", k, {d4_valid, d4_pd, d4_data}, exp4(p4, 1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_backpressure();
        test_lockup();
        test_taps();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
